// File: rtl/zx_frame_rx.sv
// Framed-packet receiver behind the zx write bus: HEAD, LEN, payload, checksum.
// Payload is staged in a FIFO, committed on a good checksum, streamed out valid/ready.
// Optional build macro FRAME_CNT_EN adds saturating ok_cnt/err_cnt frame counters.
module zx_frame_rx #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [7:0] HEAD    = 8'h55,
  parameter int         MAX_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        overflow
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;

  localparam logic [AW:0] PTR_ONE = 1;

  logic [2:0]    state;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [7:0]    cnt;
  logic [8:0]    skip;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   cm_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          byte_ev;
  logic          rd_fire;
  logic          wr_en;
  logic [AW:0]   used;
  logic [31:0]   free;

  assign byte_ev  = cs & wr;
  assign used     = wr_ptr - rd_ptr;
  assign free     = 32'(DEPTH) - 32'(used);
  assign dout_vld = (cm_ptr != rd_ptr);
  assign rd_fire  = dout_vld & dout_rdy;
  assign dout     = mem[rd_ptr[AW-1:0]];
  assign wr_en    = byte_ev && (state == S_DATA);

  // Readers only ever see bytes below cm_ptr, so uncommitted entries need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      sum       <= '0;
      cnt       <= '0;
      skip      <= '0;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      if (byte_ev) begin
        case (state)
          S_IDLE: begin
            if (din == HEAD) state <= S_LEN;
          end
          S_LEN: begin
            len <= din;
            sum <= din;
            cnt <= '0;
            if (din == 8'd0 || din > 8'(MAX_LEN)) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else if (32'(din) > free) begin
              // Whole frame is dropped: payload plus checksum byte.
              overflow <= 1'b1;
              skip     <= {1'b0, din} + 9'd1;
              state    <= S_SKIP;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            wr_ptr <= wr_ptr + PTR_ONE;
            sum    <= sum + din;
            cnt    <= cnt + 8'd1;
            if (cnt + 8'd1 == len) state <= S_CHK;
          end
          S_CHK: begin
            if (din == sum) begin
              cm_ptr   <= wr_ptr;
              frame_ok <= 1'b1;
            end else begin
              wr_ptr    <= cm_ptr;
              frame_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          S_SKIP: begin
            skip <= skip - 9'd1;
            if (skip == 9'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (frame_ok && ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
      if ((frame_err || overflow) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zx_frame_rx.sv
// Self-checking bench for zx_frame_rx: directed frames plus randomized traffic,
// compared every cycle against a frame-level model of the receiver.
module tb_zx_frame_rx;

  localparam int         DEPTH   = 16;
  localparam int         MAX_LEN = 8;
  localparam logic [7:0] HEAD    = 8'h55;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dout_rdy = 1'b0;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_ok;
  logic       frame_err;
  logic       overflow;

  zx_frame_rx #(.DEPTH(DEPTH), .AW(4), .HEAD(HEAD), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .din(din),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .frame_ok(frame_ok), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ok_seen = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  bit rand_rdy = 0;

  // Model state: committed-but-unread bytes, bytes of the frame after HEAD, skip budget.
  logic [7:0] committed[$];
  logic [7:0] frame[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];
  bit         in_frame = 0;
  int         skip_left = 0;
  logic       m_ok = 1'b0;
  logic       m_err = 1'b0;
  logic       m_ovf = 1'b0;
  bit         rd_now;
  int         fsum;
  logic [7:0] b;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      committed.delete();
      frame.delete();
      in_frame  = 0;
      skip_left = 0;
      m_ok = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      rd_now = (committed.size() > 0) && dout_rdy;
      m_ok = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
      if (cs && wr) begin
        b = din;
        if (skip_left > 0) begin
          skip_left--;
        end else if (!in_frame) begin
          if (b == HEAD) begin
            in_frame = 1;
            frame.delete();
          end
        end else begin
          frame.push_back(b);
          if (frame.size() == 1) begin
            if (b == 8'd0 || int'(b) > MAX_LEN) begin
              m_err = 1'b1;
              in_frame = 0;
            end else if (int'(b) > DEPTH - committed.size()) begin
              m_ovf = 1'b1;
              skip_left = int'(b) + 1;
              in_frame = 0;
            end
          end else if (frame.size() == int'(frame[0]) + 2) begin
            fsum = 0;
            for (int i = 0; i < frame.size() - 1; i++) fsum += int'(frame[i]);
            if (int'(b) == (fsum & 255)) begin
              m_ok = 1'b1;
              for (int i = 1; i < frame.size() - 1; i++) committed.push_back(frame[i]);
            end else begin
              m_err = 1'b1;
            end
            in_frame = 0;
          end
        end
      end
      if (rd_now) void'(committed.pop_front());
    end
  end

  always @(posedge clk) begin
    if (!rst && dout_vld && dout_rdy) got.push_back(dout);
  end

  always @(negedge clk) begin
    checkOutput("dout_vld", {31'd0, dout_vld}, {31'd0, committed.size() != 0});
    if (committed.size() != 0) checkOutput("dout", {24'd0, dout}, {24'd0, committed[0]});
    checkOutput("frame_ok", {31'd0, frame_ok}, {31'd0, m_ok});
    checkOutput("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (frame_ok) ok_seen++;
    if (frame_err) err_seen++;
    if (overflow) ovf_seen++;
  end

  task automatic applyStimulus(input logic c, input logic w, input logic [7:0] d);
    @(negedge clk);
    cs = c;
    wr = w;
    din = d;
    if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clearStats();
    ok_seen = 0;
    err_seen = 0;
    ovf_seen = 0;
    got.delete();
    expq.delete();
  endtask

  task automatic checkStream(input string name);
    checkOutput({name, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      checkOutput(name, (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, expq[i]});
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_vld"}, {31'd0, dout_vld}, 32'd0);
    checkOutput({name, "_ok"}, {31'd0, frame_ok}, 32'd0);
    checkOutput({name, "_err"}, {31'd0, frame_err}, 32'd0);
    checkOutput({name, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  task automatic sendRand(input logic [7:0] d);
    if ($urandom_range(0, 3) == 0) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
    if ($urandom_range(0, 5) == 0) applyStimulus(1'b0, 1'b1, 8'($urandom));
    sendByte(d);
  endtask

  initial begin
    int len;
    int sum;
    int kind;
    logic [7:0] pl;

    repeat (2) @(negedge clk);
    checkQuiet("reset");
    rst = 1'b0;

    // Good frame, consumer always ready.
    dout_rdy = 1'b1;
    clearStats();
    sendByte(8'h55); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h69);
    idle(6);
    expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33);
    checkStream("good_stream");
    checkOutput("good_ok_pulses", ok_seen, 1);
    checkOutput("good_vld_after", {31'd0, dout_vld}, 32'd0);

    // Bad checksum rolls back, then a one-byte frame commits alone.
    clearStats();
    sendByte(8'h55); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h70);
    idle(4);
    checkOutput("badsum_err_pulses", err_seen, 1);
    checkOutput("badsum_ok_pulses", ok_seen, 0);
    checkStream("badsum_stream");
    sendByte(8'h55); sendByte(8'h01); sendByte(8'hAA); sendByte(8'hAB);
    idle(4);
    expq.push_back(8'hAA);
    checkStream("after_badsum_stream");

    // Illegal lengths, then the next header is accepted.
    clearStats();
    sendByte(8'h55); sendByte(8'h00); idle(1);
    sendByte(8'h55); sendByte(8'h09); idle(2);
    checkOutput("badlen_err_pulses", err_seen, 2);
    sendByte(8'h55); sendByte(8'h02); sendByte(8'h01); sendByte(8'h02); sendByte(8'h05);
    idle(4);
    expq.push_back(8'h01); expq.push_back(8'h02);
    checkStream("after_badlen_stream");

    // Fill the FIFO with two 8-byte frames, then a third overflows and is skipped.
    dout_rdy = 1'b0;
    clearStats();
    sendByte(8'h55); sendByte(8'h08);
    for (int i = 1; i <= 8; i++) sendByte(8'(i));
    sendByte(8'h2C);
    sendByte(8'h55); sendByte(8'h08);
    for (int i = 0; i < 8; i++) sendByte(8'(8'h11 + i));
    sendByte(8'hAC);
    idle(2);
    checkOutput("full_ok_pulses", ok_seen, 2);
    sendByte(8'h55); sendByte(8'h08);
    for (int i = 0; i < 9; i++) sendByte(8'h55);
    idle(2);
    checkOutput("ovf_pulses", ovf_seen, 1);
    checkOutput("ovf_no_err", err_seen, 0);
    dout_rdy = 1'b1;
    idle(20);
    for (int i = 1; i <= 8; i++) expq.push_back(8'(i));
    for (int i = 0; i < 8; i++) expq.push_back(8'(8'h11 + i));
    checkStream("drain_stream");

    // Half strobes interleaved with a good frame are ignored.
    clearStats();
    applyStimulus(1'b0, 1'b1, 8'h55); applyStimulus(1'b1, 1'b0, 8'h55);
    sendByte(8'h55);
    applyStimulus(1'b0, 1'b1, 8'h09); applyStimulus(1'b1, 1'b0, 8'h00);
    sendByte(8'h03);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    sendByte(8'h11);
    applyStimulus(1'b1, 1'b0, 8'h55);
    sendByte(8'h22); sendByte(8'h33);
    applyStimulus(1'b0, 1'b1, 8'h00);
    sendByte(8'h69);
    idle(4);
    expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33);
    checkStream("strobe_stream");
    checkOutput("strobe_ok_pulses", ok_seen, 1);
    checkOutput("strobe_err_pulses", err_seen, 0);

    // Reset mid-frame; the tail of the frame is noise in IDLE.
    clearStats();
    sendByte(8'h55); sendByte(8'h03); sendByte(8'h11);
    @(negedge clk);
    rst = 1'b1; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    checkQuiet("midreset");
    rst = 1'b0;
    sendByte(8'h22); sendByte(8'h33); sendByte(8'h69);
    idle(4);
    checkOutput("midreset_vld", {31'd0, dout_vld}, 32'd0);
    checkOutput("midreset_ok_pulses", ok_seen, 0);
    checkStream("midreset_stream");

    // Randomized traffic with a random consumer; the per-cycle compare does the work.
    rand_rdy = 1;
    for (int f = 0; f < 120; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        sendRand(8'($urandom));
      end else if (kind == 1) begin
        sendRand(HEAD);
        sendRand(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(9, 255)));
      end else begin
        len = $urandom_range(1, MAX_LEN);
        sum = len;
        sendRand(HEAD);
        sendRand(8'(len));
        for (int i = 0; i < len; i++) begin
          pl = 8'($urandom);
          sum += int'(pl);
          sendRand(pl);
        end
        sendRand((kind == 2) ? 8'(sum + 1) : 8'(sum));
      end
    end
    rand_rdy = 0;
    dout_rdy = 1'b1;
    idle(40);
    checkOutput("final_drained", {31'd0, dout_vld}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
